// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// Sequences the external SRAM bus for two masters: CPU (fixed priority) and aux (only while CPU bus is free).
// Latency: request sampled at edge N -> SETUP in N+1; completion pulse in the first HOLD cycle (N+SETUP+ACCESS+1).
// Backpressure: CPU is stretched via cpu_stall_o until cpu_done_o; aux holds aux_req_i until aux_ack_o.
module sram_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk6x,
    input  logic              resetn,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_rwn_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic [7:0]        cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,
    input  logic              cpu_bus_free_i,
    input  logic              aux_req_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic              aux_rwn_i,
    input  logic [7:0]        aux_wdata_i,
    output logic              aux_ack_o,
    output logic [7:0]        aux_rdata_o,
    output logic              aux_rvalid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mal_oe_o,
    output logic              m1csn_o,
    output logic              mrdn_o,
    output logic              mwrn_o,
    output logic [7:0]        md_o,
    output logic              md_oe_o,
    input  logic [7:0]        md_i
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYC - 1);
    localparam logic [2:0] ACCESS_LAST = 3'(ACCESS_CYC - 1);
    localparam logic [2:0] HOLD_LAST   = 3'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;   // 1 = aux owns the current access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rwn_q, rwn_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        aux_rdata_q, aux_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              aux_ack_q, aux_ack_d;
    logic              aux_rvalid_q, aux_rvalid_d;
    logic              m1csn_q, m1csn_d;
    logic              mrdn_q, mrdn_d;
    logic              mwrn_q, mwrn_d;
    logic              md_oe_q, md_oe_d;
    logic              mal_oe_q, mal_oe_d;
    logic              grant_pt;

    // Next-state, grant and completion logic; pin outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        rwn_d        = rwn_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        aux_rdata_d  = aux_rdata_q;
        cpu_done_d   = 1'b0;
        aux_ack_d    = 1'b0;
        aux_rvalid_d = 1'b0;
        grant_pt     = 1'b0;

        case (state_q)
            IDLE: grant_pt = 1'b1;
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            STROBE: begin
                if (cnt_q == ACCESS_LAST) begin
                    // Read data is taken on the edge that ends the strobe; the pulse lands in the first HOLD cycle.
                    state_d = HOLD;
                    cnt_d   = 3'd0;
                    if (!owner_q) begin
                        cpu_done_d = 1'b1;
                        if (rwn_q) cpu_rdata_d = md_i;
                    end else if (rwn_q) begin
                        aux_rvalid_d = 1'b1;
                        aux_rdata_d  = md_i;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    grant_pt = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant in the last HOLD cycle chains straight into SETUP, keeping chip-select low.
        if (grant_pt) begin
            if (cpu_req_i) begin
                state_d = SETUP;
                cnt_d   = 3'd0;
                owner_d = 1'b0;
                addr_d  = cpu_addr_i;
                rwn_d   = cpu_rwn_i;
                wdata_d = cpu_wdata_i;
            end else if (aux_req_i && cpu_bus_free_i) begin
                state_d   = SETUP;
                cnt_d     = 3'd0;
                owner_d   = 1'b1;
                addr_d    = aux_addr_i;
                rwn_d     = aux_rwn_i;
                wdata_d   = aux_wdata_i;
                aux_ack_d = 1'b1;
            end
        end

        m1csn_d  = (state_d == IDLE);
        mrdn_d   = !((state_d == STROBE) && rwn_d);
        mwrn_d   = !((state_d == STROBE) && !rwn_d);
        md_oe_d  = (state_d != IDLE) && !rwn_d;
        mal_oe_d = (state_d != IDLE) && owner_d;
    end

    // State and output registers; reset drops any access in flight without a completion pulse.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            rwn_q        <= 1'b1;
            wdata_q      <= 8'h00;
            cpu_rdata_q  <= 8'h00;
            aux_rdata_q  <= 8'h00;
            cpu_done_q   <= 1'b0;
            aux_ack_q    <= 1'b0;
            aux_rvalid_q <= 1'b0;
            m1csn_q      <= 1'b1;
            mrdn_q       <= 1'b1;
            mwrn_q       <= 1'b1;
            md_oe_q      <= 1'b0;
            mal_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            rwn_q        <= rwn_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
            cpu_done_q   <= cpu_done_d;
            aux_ack_q    <= aux_ack_d;
            aux_rvalid_q <= aux_rvalid_d;
            m1csn_q      <= m1csn_d;
            mrdn_q       <= mrdn_d;
            mwrn_q       <= mwrn_d;
            md_oe_q      <= md_oe_d;
            mal_oe_q     <= mal_oe_d;
        end
    end

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_done_o   = cpu_done_q;
    assign cpu_stall_o  = cpu_req_i && !cpu_done_q;
    assign aux_ack_o    = aux_ack_q;
    assign aux_rdata_o  = aux_rdata_q;
    assign aux_rvalid_o = aux_rvalid_q;
    assign mem_addr_o   = addr_q;
    assign mal_oe_o     = mal_oe_q;
    assign m1csn_o      = m1csn_q;
    assign mrdn_o       = mrdn_q;
    assign mwrn_o       = mwrn_q;
    assign md_o         = wdata_q;
    assign md_oe_o      = md_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for sram_arbiter: directed arbitration/timing cases plus random CPU/aux traffic.
// Expected read data comes from a reference memory updated in issue order; a monitor pops it on each completion.
// An SRAM pin model behind the DUT stores writes on the MWRn rising edge and returns data while MRDn is low.
module tb_sram_arbiter;

    localparam int AW  = 21;
    localparam int ACC = 2;

    logic          clk6x = 1'b0;
    logic          resetn;
    logic          cpu_req, cpu_rwn, aux_req, aux_rwn, bus_free;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [7:0]    cpu_wdata, aux_wdata;
    logic [7:0]    cpu_rdata_o, aux_rdata_o, md_o, md_i;
    logic          cpu_done_o, cpu_stall_o, aux_ack_o, aux_rvalid_o;
    logic [AW-1:0] mem_addr_o;
    logic          mal_oe_o, m1csn_o, mrdn_o, mwrn_o, md_oe_o;

    sram_arbiter #(.ADDR_W(AW), .SETUP_CYC(1), .ACCESS_CYC(ACC), .HOLD_CYC(1)) dut (
        .clk6x(clk6x), .resetn(resetn),
        .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_rwn_i(cpu_rwn), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o), .cpu_stall_o(cpu_stall_o),
        .cpu_bus_free_i(bus_free),
        .aux_req_i(aux_req), .aux_addr_i(aux_addr), .aux_rwn_i(aux_rwn), .aux_wdata_i(aux_wdata),
        .aux_ack_o(aux_ack_o), .aux_rdata_o(aux_rdata_o), .aux_rvalid_o(aux_rvalid_o),
        .mem_addr_o(mem_addr_o), .mal_oe_o(mal_oe_o), .m1csn_o(m1csn_o), .mrdn_o(mrdn_o),
        .mwrn_o(mwrn_o), .md_o(md_o), .md_oe_o(md_oe_o), .md_i(md_i)
    );

    always #5 clk6x = ~clk6x;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk6x) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM pin model
    logic [7:0] sram [logic [AW-1:0]];
    function automatic logic [7:0] sram_rd(input logic [AW-1:0] a);
        return sram.exists(a) ? sram[a] : 8'h00;
    endfunction
    always @(posedge mwrn_o) if (resetn === 1'b1) sram[mem_addr_o] = md_o;
    always @(negedge clk6x) md_i = (mrdn_o == 1'b0) ? sram_rd(mem_addr_o) : 8'h00;

    // Reference model and scoreboard queues
    typedef struct { logic rd; logic [7:0] data; } exp_t;
    exp_t       cpu_q[$];
    logic [7:0] aux_q[$];
    logic [7:0] ref_mem [logic [AW-1:0]];
    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Monitor: pin invariants, strobe widths, and completion checking against the queues
    exp_t mon_e;
    int   rd_low = 0, wr_low = 0;
    always @(posedge clk6x) begin
        #1;
        if (resetn) begin
            chk("strobes_exclusive", {31'd0, !(mrdn_o == 1'b0 && mwrn_o == 1'b0)}, 1);
            chk("strobe_needs_cs", {31'd0, (mrdn_o & mwrn_o) | ~m1csn_o}, 1);
        end
        if (cpu_done_o) begin
            if (cpu_q.size() == 0) chk("cpu_done_unexpected", 1, 0);
            else begin
                mon_e = cpu_q.pop_front();
                if (mon_e.rd) chk("cpu_rdata", {24'd0, cpu_rdata_o}, {24'd0, mon_e.data});
            end
        end
        if (aux_rvalid_o) begin
            if (aux_q.size() == 0) chk("aux_rvalid_unexpected", 1, 0);
            else chk("aux_rdata", {24'd0, aux_rdata_o}, {24'd0, aux_q.pop_front()});
        end
        if (!resetn) begin
            rd_low = 0; wr_low = 0;
        end else begin
            if (!mrdn_o) rd_low++;
            else if (rd_low > 0) begin chk("mrdn_width", rd_low, ACC); rd_low = 0; end
            if (!mwrn_o) wr_low++;
            else if (wr_low > 0) begin chk("mwrn_width", wr_low, ACC); wr_low = 0; end
        end
    end

    int   done_cyc, ack_cyc;
    logic cs_at_done, mal_at_done, cs_at_ack, mal_at_ack;

    // Called just after a rising edge; returns in the cycle cpu_done_o is seen (request already dropped).
    task automatic cpu_access(input logic [AW-1:0] a, input logic rd, input logic [7:0] wd, input int exp_lat);
        int issue;
        bit seen;
        cpu_addr = a; cpu_rwn = rd; cpu_wdata = wd; cpu_req = 1'b1; issue = cyc;
        if (rd) cpu_q.push_back('{1'b1, ref_rd(a)});
        else begin ref_mem[a] = wd; cpu_q.push_back('{1'b0, wd}); end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk6x); #1;
            if (cpu_done_o) seen = 1'b1;
            else chk("cpu_stall_while_pending", {31'd0, cpu_stall_o}, 1);
        end
        if (seen) begin
            done_cyc = cyc; cs_at_done = m1csn_o; mal_at_done = mal_oe_o;
            if (exp_lat > 0) chk("cpu_latency", cyc - issue, exp_lat);
        end else chk("cpu_done_timeout", 0, 1);
        cpu_req = 1'b0;
        chk("cpu_stall_after_done", {31'd0, cpu_stall_o}, 0);
    endtask

    // Called just after a rising edge; returns one cycle after aux_ack_o is seen.
    task automatic aux_access(input logic [AW-1:0] a, input logic rd, input logic [7:0] wd);
        bit seen;
        aux_addr = a; aux_rwn = rd; aux_wdata = wd; aux_req = 1'b1;
        if (rd) aux_q.push_back(ref_rd(a));
        else ref_mem[a] = wd;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(posedge clk6x); #1;
            if (aux_ack_o) begin
                seen = 1'b1; ack_cyc = cyc; cs_at_ack = m1csn_o; mal_at_ack = mal_oe_o;
                aux_req = 1'b0;
            end
        end
        aux_req = 1'b0;
        if (!seen) chk("aux_ack_timeout", 0, 1);
        else begin
            @(posedge clk6x); #1;
            chk("aux_ack_single", {31'd0, aux_ack_o}, 0);
        end
    endtask

    initial begin
        logic       any_ack;
        int         raise_cyc, ndone, cs_high, first_done, last_done;
        int         mode;
        logic [7:0] d1, d2;
        logic       r1, r2;
        logic [AW-1:0] a1, a2;

        resetn = 1'b0; cpu_req = 1'b0; aux_req = 1'b0; bus_free = 1'b1;
        cpu_addr = '0; cpu_rwn = 1'b1; cpu_wdata = 8'h00;
        aux_addr = '0; aux_rwn = 1'b1; aux_wdata = 8'h00;
        repeat (3) @(posedge clk6x);
        #1;
        chk("rst_m1csn", {31'd0, m1csn_o}, 1);
        chk("rst_mrdn", {31'd0, mrdn_o}, 1);
        chk("rst_mwrn", {31'd0, mwrn_o}, 1);
        chk("rst_md_oe", {31'd0, md_oe_o}, 0);
        chk("rst_mal_oe", {31'd0, mal_oe_o}, 0);
        chk("rst_pulses", {29'd0, cpu_done_o, aux_ack_o, aux_rvalid_o}, 0);
        chk("rst_rdata", {16'd0, cpu_rdata_o, aux_rdata_o}, 0);
        chk("rst_md_addr", {3'd0, md_o, mem_addr_o}, 0);
        resetn = 1'b1;
        @(posedge clk6x); #1;

        // CPU write then read back, both from idle
        cpu_access(21'h00010, 1'b0, 8'h12, 4);
        @(posedge clk6x); #1;
        cpu_access(21'h00010, 1'b1, 8'h00, 4);
        chk("cpu_read_0x10", {24'd0, cpu_rdata_o}, 32'h12);
        @(posedge clk6x); #1;

        // Simultaneous requests: CPU first, aux chained with continuous chip-select
        fork
            cpu_access(21'h00020, 1'b0, 8'h3C, 4);
            aux_access(21'h10020, 1'b0, 8'hC3);
        join
        chk("aux_ack_after_cpu_hold", ack_cyc - done_cyc, 1);
        chk("cs_low_cpu_hold", {31'd0, cs_at_done}, 0);
        chk("cs_low_aux_setup", {31'd0, cs_at_ack}, 0);
        chk("mal_oe_cpu", {31'd0, mal_at_done}, 0);
        chk("mal_oe_aux", {31'd0, mal_at_ack}, 1);
        repeat (4) @(posedge clk6x); #1;

        // Aux blocked while the CPU owns the bus, then granted one cycle after release
        bus_free = 1'b0;
        any_ack = 1'b0;
        fork
            aux_access(21'h1ABCD, 1'b0, 8'hA5);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk6x); #1;
                    any_ack |= aux_ack_o;
                end
                chk("aux_blocked_no_ack", {31'd0, any_ack}, 0);
                bus_free = 1'b1; raise_cyc = cyc;
            end
        join
        chk("aux_ack_after_free", ack_cyc - raise_cyc, 1);
        aux_access(21'h1ABCD, 1'b1, 8'h00);
        any_ack = 1'b0;
        for (int i = 0; i < 20 && !any_ack; i++) begin
            @(posedge clk6x); #1;
            any_ack = aux_rvalid_o;
        end
        chk("aux_rvalid_seen", {31'd0, any_ack}, 1);
        chk("aux_read_0x1abcd", {24'd0, aux_rdata_o}, 32'hA5);
        repeat (3) @(posedge clk6x); #1;

        // Bus taken back and CPU request during the aux strobe: aux completes, CPU waits 5 cycles
        fork
            aux_access(21'h1ABCD, 1'b1, 8'h00);
            begin
                any_ack = 1'b0;
                for (int i = 0; i < 20 && !any_ack; i++) begin
                    @(posedge clk6x); #1;
                    any_ack = aux_ack_o;
                end
                repeat (2) @(posedge clk6x); #1;
                bus_free = 1'b0;
                cpu_access(21'h00010, 1'b1, 8'h00, 5);
            end
        join
        bus_free = 1'b1;
        repeat (4) @(posedge clk6x); #1;

        // Reset during a write strobe drops the access
        cpu_addr = 21'h0FFF0; cpu_rwn = 1'b0; cpu_wdata = 8'h77; cpu_req = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 10 && !any_ack; i++) begin
            @(posedge clk6x); #1;
            any_ack = !mwrn_o;
        end
        chk("mwrn_reached", {31'd0, any_ack}, 1);
        resetn = 1'b0;
        @(posedge clk6x); #1;
        chk("rst_mid_mwrn", {31'd0, mwrn_o}, 1);
        chk("rst_mid_m1csn", {31'd0, m1csn_o}, 1);
        chk("rst_mid_md_oe", {31'd0, md_oe_o}, 0);
        chk("rst_mid_no_done", {31'd0, cpu_done_o}, 0);
        cpu_req = 1'b0;
        @(posedge clk6x); #1;
        resetn = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk6x); #1;
            any_ack |= cpu_done_o;
        end
        chk("rst_mid_no_late_done", {31'd0, any_ack}, 0);

        // Back-to-back CPU reads with request held: one every 4 cycles, chip-select never released
        for (int i = 0; i < 4; i++) cpu_q.push_back('{1'b1, ref_rd(21'h00020)});
        cpu_addr = 21'h00020; cpu_rwn = 1'b1; cpu_req = 1'b1;
        ndone = 0; cs_high = 0; first_done = 0; last_done = 0;
        for (int i = 0; i < 60 && ndone < 4; i++) begin
            @(posedge clk6x); #1;
            if (ndone > 0 && m1csn_o) cs_high++;
            if (cpu_done_o) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                last_done = cyc;
                if (ndone == 4) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("b2b_count", ndone, 4);
        chk("b2b_span", last_done - first_done, 12);
        chk("b2b_cs_continuous", cs_high, 0);
        @(posedge clk6x); #1;

        // Random mixed traffic; CPU and aux use disjoint address windows
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            a1 = 21'($urandom_range(0, 15));
            a2 = 21'h100000 + 21'($urandom_range(0, 15));
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            d1 = 8'($urandom_range(0, 255));
            d2 = 8'($urandom_range(0, 255));
            case (mode)
                0: cpu_access(a1, r1, d1, 0);
                1: aux_access(a2, r2, d2);
                default: fork
                    cpu_access(a1, r1, d1, 0);
                    aux_access(a2, r2, d2);
                join
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk6x);
            #1;
        end

        repeat (20) @(posedge clk6x); #1;
        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("aux_queue_drained", aux_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
